ppu_clk_monitor: RTL and testbench

Frequency and lock monitor for the PPU clock generated by the rPLL from the 27 MHz board clock. It runs in the 27 MHz domain and receives a toggle signal, ppu_tgl, that the PPU domain flips every 8 PPU clocks. The block counts ppu_tgl edges over a fixed gate window and checks each count against an expected range. It asserts clk_ok after consecutive good windows, and reports stalls and loss-of-lock to the system controller.

---
 rtl/ppu_clk_mon_pkg.sv | 22 ++
 rtl/tgl_edge_sync.sv | 40 ++++
 rtl/ppu_clk_monitor.sv | 164 ++++++++++++++++
 tb/tb_ppu_clk_monitor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_clk_mon_pkg.sv
// ppu_clk_mon_pkg
// Shared types and default constants for the PPU clock monitor.
// - mon_state_e : monitor FSM state (IDLE, ACQUIRE, LOCKED)
// - *_DEF       : default parameter values for a 27 MHz reference and a
//                 50.14 MHz PPU clock whose toggle flips every 8 PPU clocks
package ppu_clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_e;

  localparam int GATE_CYCLES_DEF  = 27000;  // 1 ms at 27 MHz
  localparam int EXP_MIN_DEF      = 6200;
  localparam int EXP_MAX_DEF      = 6330;
  localparam int NOMINAL_COUNT    = 6268;   // 50.14 MHz / 8 over 1 ms
  localparam int GOOD_WINDOWS_DEF = 4;
  localparam int STALL_CYCLES_DEF = 64;
  localparam int CNT_W_DEF        = 16;

endpackage

// File: rtl/tgl_edge_sync.sv
// tgl_edge_sync
// Brings the asynchronous PPU-domain toggle into the clkin domain through a
// two-flop synchronizer, then compares against a history flop to produce a
// one-cycle pulse per toggle transition (3 cycles input-to-pulse).
// Ports:
//   clkin    in  reference clock
//   rst      in  asynchronous active-high reset
//   tgl_in   in  asynchronous toggle
//   edge_o   out one-cycle pulse for every transition of tgl_in
module tgl_edge_sync (
  input  logic clkin,
  input  logic rst,
  input  logic tgl_in,
  output logic edge_o
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = tgl_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign edge_o = s2_q ^ s3_q;

endmodule

// File: rtl/ppu_clk_monitor.sv
// ppu_clk_monitor
// Measures the PPU clock against clkin by counting toggle edges over a fixed
// gate window. Consecutive in-range windows declare lock; an out-of-range
// window or a stall (no edges for STALL_CYCLES) while locked drops lock and
// latches fault_sticky.
// Ports:
//   clkin        in  27 MHz reference clock
//   rst          in  asynchronous active-high reset
//   en           in  monitor enable (level); low forces IDLE
//   ppu_tgl      in  asynchronous toggle from the PPU domain
//   fault_clr    in  one-cycle pulse clearing fault_sticky
//   clk_ok       out locked indication
//   meas_valid   out one-cycle pulse at each completed window
//   meas_count   out saturated edge count of the last completed window
//   fault_sticky out latched loss-of-lock indication
module ppu_clk_monitor
  import ppu_clk_mon_pkg::*;
#(
  parameter int GATE_CYCLES  = GATE_CYCLES_DEF,
  parameter int EXP_MIN      = EXP_MIN_DEF,
  parameter int EXP_MAX      = EXP_MAX_DEF,
  parameter int GOOD_WINDOWS = GOOD_WINDOWS_DEF,
  parameter int STALL_CYCLES = STALL_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             ppu_tgl,
  input  logic             fault_clr,
  output logic             clk_ok,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_count,
  output logic             fault_sticky
);

  localparam int GATE_W  = $clog2(GATE_CYCLES);
  localparam int STALL_W = $clog2(STALL_CYCLES);
  localparam int GOOD_W  = $clog2(GOOD_WINDOWS + 1);

  localparam logic [GATE_W-1:0]  GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
  localparam logic [GOOD_W-1:0]  GOOD_LAST  = GOOD_W'(GOOD_WINDOWS - 1);

  mon_state_e         state_q, state_d;
  logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0]   meas_count_q, meas_count_d;
  logic               meas_valid_q, meas_valid_d;
  logic               fault_q, fault_d;

  logic             edge_pulse;
  logic [CNT_W:0]   edge_sum;
  logic [CNT_W-1:0] edge_sat;
  logic [31:0]      cnt_ext;
  logic             win_end, win_good, stall;
  logic             fault_set;

  tgl_edge_sync u_sync (
    .clkin  (clkin),
    .rst    (rst),
    .tgl_in (ppu_tgl),
    .edge_o (edge_pulse)
  );

  // The edge arriving on the window's last cycle still belongs to that window.
  assign edge_sum = {1'b0, edge_cnt_q} + {{CNT_W{1'b0}}, edge_pulse};
  assign edge_sat = edge_sum[CNT_W] ? {CNT_W{1'b1}} : edge_sum[CNT_W-1:0];
  assign cnt_ext  = 32'(edge_sat);
  assign win_good = (cnt_ext >= 32'(EXP_MIN)) && (cnt_ext <= 32'(EXP_MAX));
  assign win_end  = (gate_cnt_q == GATE_LAST);
  assign stall    = (stall_cnt_q == STALL_LAST) && !edge_pulse;

  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    good_cnt_d   = good_cnt_q;
    meas_count_d = meas_count_q;
    meas_valid_d = 1'b0;
    fault_set    = 1'b0;

    if (state_q == IDLE || !en) begin
      gate_cnt_d  = '0;
      edge_cnt_d  = '0;
      stall_cnt_d = '0;
      good_cnt_d  = '0;
      state_d     = en ? ACQUIRE : IDLE;
    end else if (stall) begin
      // Stall discards the window even if it coincides with window end.
      gate_cnt_d  = '0;
      edge_cnt_d  = '0;
      stall_cnt_d = '0;
      good_cnt_d  = '0;
      if (state_q == LOCKED) begin
        state_d   = ACQUIRE;
        fault_set = 1'b1;
      end
    end else begin
      stall_cnt_d = edge_pulse ? '0 : stall_cnt_q + 1'b1;
      if (win_end) begin
        gate_cnt_d   = '0;
        edge_cnt_d   = '0;
        meas_count_d = edge_sat;
        meas_valid_d = 1'b1;
        if (win_good) begin
          if (state_q == ACQUIRE) begin
            if (good_cnt_q == GOOD_LAST) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end
        end else begin
          good_cnt_d = '0;
          if (state_q == LOCKED) begin
            state_d   = ACQUIRE;
            fault_set = 1'b1;
          end
        end
      end else begin
        gate_cnt_d = gate_cnt_q + 1'b1;
        edge_cnt_d = edge_sat;
      end
    end

    // A new fault outranks a simultaneous clear.
    if (fault_set)      fault_d = 1'b1;
    else if (fault_clr) fault_d = 1'b0;
    else                fault_d = fault_q;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      good_cnt_q   <= '0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      good_cnt_q   <= good_cnt_d;
      meas_count_q <= meas_count_d;
      meas_valid_q <= meas_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign clk_ok       = (state_q == LOCKED);
  assign meas_valid   = meas_valid_q;
  assign meas_count   = meas_count_q;
  assign fault_sticky = fault_q;

endmodule

// File: tb/tb_ppu_clk_monitor.sv
// Bench for ppu_clk_monitor: two instances (8-bit and 6-bit counters) share
// all inputs and are compared every cycle against a behavioural model.
module tb_ppu_clk_monitor;

  localparam int GATE  = 100;
  localparam int EMIN  = 20;
  localparam int EMAX  = 26;
  localparam int GOODW = 2;
  localparam int STALL = 40;

  logic       clkin = 1'b0;
  logic       rst, en, ppu_tgl, fault_clr;
  logic       ok8, mv8, fs8, ok6, mv6, fs6;
  logic [7:0] mc8;
  logic [5:0] mc6;

  always #5 clkin = ~clkin;

  ppu_clk_monitor #(.GATE_CYCLES(GATE), .EXP_MIN(EMIN), .EXP_MAX(EMAX),
    .GOOD_WINDOWS(GOODW), .STALL_CYCLES(STALL), .CNT_W(8)) dut8 (
    .clkin(clkin), .rst(rst), .en(en), .ppu_tgl(ppu_tgl), .fault_clr(fault_clr),
    .clk_ok(ok8), .meas_valid(mv8), .meas_count(mc8), .fault_sticky(fs8));

  ppu_clk_monitor #(.GATE_CYCLES(GATE), .EXP_MIN(EMIN), .EXP_MAX(EMAX),
    .GOOD_WINDOWS(GOODW), .STALL_CYCLES(STALL), .CNT_W(6)) dut6 (
    .clkin(clkin), .rst(rst), .en(en), .ppu_tgl(ppu_tgl), .fault_clr(fault_clr),
    .clk_ok(ok6), .meas_valid(mv6), .meas_count(mc6), .fault_sticky(fs6));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 acquiring, 2 locked
  int m_mode, m_pos, m_edges, m_since, m_good, m_raw;
  bit m_mv, m_fs;
  bit hist[$];  // ppu_tgl as sampled at recent clkin edges, newest first

  function automatic void model_reset();
    m_mode = 0; m_pos = 0; m_edges = 0; m_since = 0; m_good = 0; m_raw = 0;
    m_mv = 0; m_fs = 0;
    hist.delete();
    repeat (3) hist.push_back(1'b0);
  endfunction

  function automatic void clear_win();
    m_pos = 0; m_edges = 0; m_since = 0; m_good = 0;
  endfunction

  function automatic bit edge_now();
    return hist[1] != hist[2];
  endfunction

  function automatic bit stall_next();
    return (m_mode != 0) && en && !edge_now() && (m_since == STALL - 1);
  endfunction

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  function automatic void model_step();
    bit e, fault;
    e = edge_now();
    fault = 0;
    m_mv = 0;
    if (m_mode == 0) begin
      clear_win();
      if (en) m_mode = 1;
    end else if (!en) begin
      m_mode = 0;
      clear_win();
    end else if (!e && m_since == STALL - 1) begin
      clear_win();
      if (m_mode == 2) begin m_mode = 1; fault = 1; end
    end else begin
      m_since = e ? 0 : m_since + 1;
      if (m_pos == GATE - 1) begin
        m_raw = m_edges + int'(e);
        m_mv = 1; m_pos = 0; m_edges = 0;
        if (m_raw >= EMIN && m_raw <= EMAX) begin
          if (m_mode == 1) begin
            m_good++;
            if (m_good == GOODW) begin m_mode = 2; m_good = 0; end
          end
        end else begin
          m_good = 0;
          if (m_mode == 2) begin m_mode = 1; fault = 1; end
        end
      end else begin
        m_pos++;
        m_edges += int'(e);
      end
    end
    if (fault) m_fs = 1;
    else if (fault_clr) m_fs = 0;
    hist.push_front(ppu_tgl);
    void'(hist.pop_back());
  endfunction

  // ---------------- stimulus helpers ----------------
  int per = 0, tctr = 0, cyc = 0, tog_step = 0;

  task automatic compare_all();
    chk("clk_ok8", {31'd0, ok8}, {31'd0, m_mode == 2});
    chk("meas_valid8", {31'd0, mv8}, {31'd0, m_mv});
    chk("meas_count8", {24'd0, mc8}, sat(m_raw, 8));
    chk("fault8", {31'd0, fs8}, {31'd0, m_fs});
    chk("clk_ok6", {31'd0, ok6}, {31'd0, m_mode == 2});
    chk("meas_valid6", {31'd0, mv6}, {31'd0, m_mv});
    chk("meas_count6", {26'd0, mc6}, sat(m_raw, 6));
    chk("fault6", {31'd0, fs6}, {31'd0, m_fs});
  endtask

  task automatic step();
    @(posedge clkin);
    model_step();
    @(negedge clkin);
    compare_all();
    cyc++;
    tctr++;
    if (per != 0 && tctr >= per) begin
      ppu_tgl = ~ppu_tgl;
      tctr = 0;
      tog_step = cyc;
    end
    fault_clr = 1'b0;
  endtask

  task automatic wait_mv(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      n++;
      if (mv8) return;
    end
    chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic lock_up(input string tag);
    int n;
    for (int i = 0; i < 6 && !ok8; i++) wait_mv(tag, n);
    chk(tag, {31'd0, ok8}, 1);
  endtask

  int n, fall, mv_cnt, saved;
  bit stall_hit;

  initial begin
    rst = 1'b1; en = 1'b0; ppu_tgl = 1'b0; fault_clr = 1'b0;
    model_reset();
    #12;
    chk("rst_clk_ok", {31'd0, ok8}, 0);
    chk("rst_meas_valid", {31'd0, mv8}, 0);
    chk("rst_meas_count", {24'd0, mc8}, 0);
    chk("rst_fault", {31'd0, fs8}, 0);
    @(negedge clkin);
    rst = 1'b0;

    // Lock acquire at nominal rate (toggle every 4 clkin)
    en = 1'b1; per = 4;
    wait_mv("win1", n);
    chk("win1_latency", n, GATE + 1);
    chk("win1_not_locked", {31'd0, ok8}, 0);
    wait_mv("win2", n);
    chk("win2_latency", n, GATE);
    chk("lock_at_2nd", {31'd0, ok8}, 1);
    chk("lock_count_rng", {31'd0, mc8 >= 24 && mc8 <= 25}, 1);

    // Frequency too low while locked
    per = 8;
    wait_mv("slow", n);
    chk("slow_count_rng", {31'd0, mc8 >= 12 && mc8 <= 13}, 1);
    chk("slow_unlock", {31'd0, ok8}, 0);
    chk("slow_fault", {31'd0, fs8}, 1);
    fault_clr = 1'b1;
    step();
    chk("fault_cleared", {31'd0, fs8}, 0);

    // Stall while locked, with fault_clr on the stall cycle
    per = 4;
    lock_up("relock1");
    wait_mv("pre_stall", n);
    per = 0; fall = -1; mv_cnt = 0; stall_hit = 0;
    for (int i = 0; i < 160; i++) begin
      if (stall_next() && m_mode == 2) begin fault_clr = 1'b1; stall_hit = 1; end
      step();
      if (mv8) mv_cnt++;
      if (fall < 0 && !ok8) begin
        fall = cyc;
        chk("clr_vs_stall", {31'd0, fs8}, 1);
      end
    end
    chk("stall_seen", {31'd0, stall_hit}, 1);
    chk("stall_latency", fall - tog_step, STALL + 3);
    chk("stall_no_mv", mv_cnt, 0);
    per = 4;
    lock_up("relock2");

    // Every-cycle toggling: 100 edges, saturates the 6-bit counter
    per = 1;
    wait_mv("fast1", n);
    wait_mv("fast2", n);
    chk("sat6", {26'd0, mc6}, 63);
    chk("cnt8_fast", {24'd0, mc8}, GATE);
    chk("fast_bad", {31'd0, ok8}, 0);

    // en drop mid-window
    per = 4;
    lock_up("relock3");
    repeat (30) step();
    saved = mc8; mv_cnt = 0;
    en = 1'b0;
    repeat (150) begin step(); if (mv8) mv_cnt++; end
    chk("en0_no_mv", mv_cnt, 0);
    chk("en0_hold_count", {24'd0, mc8}, saved);
    chk("en0_clk_ok", {31'd0, ok8}, 0);
    en = 1'b1;

    // Asynchronous reset between clock edges, mid-window
    wait_mv("pre_rst", n);
    repeat (37) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_clk_ok", {31'd0, ok8}, 0);
    chk("arst_meas_valid", {31'd0, mv8 | mv6}, 0);
    chk("arst_meas_count", {24'd0, mc8}, 0);
    chk("arst_fault", {31'd0, fs8}, 0);
    model_reset();
    @(posedge clkin);
    @(negedge clkin);
    rst = 1'b0;
    wait_mv("post_rst", n);
    chk("post_rst_latency", n, GATE + 1);

    // Randomized phases: rate, length, clears and enable drops
    for (int ph = 0; ph < 14; ph++) begin
      per = $urandom_range(0, 10);
      for (int i = $urandom_range(40, 300); i > 0; i--) begin
        fault_clr = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 199) == 0) en = ~en;
        step();
      end
      en = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
